// File: rtl/calc_pkg.sv
// Shared types and width helpers for the calculator operand-entry slice.
package calc_pkg;

  localparam int DEFAULT_DIGIT_W = 4;
  localparam int KEY_IDLE        = 0;

  typedef enum logic {
    ENTRY = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int key_w(input int num_ops);
    return $clog2(num_ops + 1);
  endfunction

  // Operand index width; never zero so a single operand still gets a 1-bit select.
  function automatic int sel_w(input int num_ops);
    return (num_ops > 1) ? $clog2(num_ops) : 1;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Key edge detector: one event per change of key code into a valid operand select.
module key_edge_det
  import calc_pkg::*;
#(
  parameter int KEY_W   = 2,
  parameter int NUM_OPS = 2,
  parameter int SEL_W   = sel_w(NUM_OPS)
) (
  input  logic             clk_sw,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  output logic             evt,
  output logic [SEL_W-1:0] sel
);

  localparam logic [KEY_W-1:0] KEY_MAX  = KEY_W'(NUM_OPS);
  localparam logic [KEY_W-1:0] KEY_NONE = KEY_W'(KEY_IDLE);

  logic [KEY_W-1:0] key_prev;
  logic [KEY_W-1:0] key_m1;

  // Out-of-range codes still land in key_prev so returning to a valid code fires.
  always_ff @(posedge clk_sw or negedge rst_n) begin
    if (!rst_n) key_prev <= '0;
    else        key_prev <= key;
  end

  assign key_m1 = key - KEY_W'(1);
  assign evt    = (key != key_prev) && (key != KEY_NONE) && (key <= KEY_MAX);
  assign sel    = SEL_W'(key_m1);

endmodule

// File: rtl/operand_entry.sv
// Operand entry: shifts switch digits into NUM_OPS operands and offers them to the ALU.
// Define OPERAND_ENTRY_SYNC_EN to add 2-flop synchronisers on digit, key and clear inputs.
//
// state | meaning
// ENTRY | collecting digits; at least one operand is still empty
// READY | every operand holds a digit; ops_valid high until handshake or clear
module operand_entry
  import calc_pkg::*;
#(
  parameter int DIGIT_W   = DEFAULT_DIGIT_W,
  parameter int DIGITS    = 2,
  parameter int NUM_OPS   = 2,
  parameter bit INVERT_IN = 1'b1,
  parameter int OP_W      = DIGIT_W * DIGITS,
  parameter int KEY_W     = key_w(NUM_OPS)
) (
  input  logic                     clk_sw,
  input  logic                     rst_n,
  input  logic [DIGIT_W-1:0]       in_number_from_top,
  input  logic [KEY_W-1:0]         key_from_top,
  input  logic                     clr_from_top,
  input  logic                     ops_ready,
  output logic [NUM_OPS*OP_W-1:0]  ops_bus,
  output logic                     ops_valid,
  output logic                     ovf,
  output logic [OP_W-1:0]          ind
);

  localparam int SEL_W = sel_w(NUM_OPS);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [DIGIT_W-1:0] num_s;
  logic [KEY_W-1:0]   key_s;
  logic               clr_s;

`ifdef OPERAND_ENTRY_SYNC_EN
  // Digit, key and clear share one synchroniser so their cycle alignment is kept.
  logic [DIGIT_W+KEY_W:0] sync_q1;
  logic [DIGIT_W+KEY_W:0] sync_q2;

  always_ff @(posedge clk_sw or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {clr_from_top, key_from_top, in_number_from_top};
      sync_q2 <= sync_q1;
    end
  end

  assign {clr_s, key_s, num_s} = sync_q2;
`else
  assign num_s = in_number_from_top;
  assign key_s = key_from_top;
  assign clr_s = clr_from_top;
`endif

  logic [DIGIT_W-1:0] digit;
  assign digit = INVERT_IN ? ~num_s : num_s;

  logic             evt;
  logic [SEL_W-1:0] sel;

  key_edge_det #(
    .KEY_W   (KEY_W),
    .NUM_OPS (NUM_OPS),
    .SEL_W   (SEL_W)
  ) u_key_edge_det (
    .clk_sw (clk_sw),
    .rst_n  (rst_n),
    .key    (key_s),
    .evt    (evt),
    .sel    (sel)
  );

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0]  op_q  [NUM_OPS];
  logic [OP_W-1:0]  op_d  [NUM_OPS];
  logic [CNT_W-1:0] cnt_q [NUM_OPS];
  logic [CNT_W-1:0] cnt_d [NUM_OPS];
  logic [SEL_W-1:0] last_sel_q;
  logic [SEL_W-1:0] last_sel_d;
  logic             ovf_d;
  logic [OP_W-1:0]  ind_d;

  logic [OP_W-1:0]  op_sel;
  logic [OP_W-1:0]  op_shift;
  logic [CNT_W-1:0] cnt_sel;
  logic             sel_full;
  logic             clear;
  logic             do_key;
  logic             all_filled;

  // Clear beats handshake beats key event; a dropped key is still remembered by the detector.
  always_comb begin
    op_sel  = '0;
    cnt_sel = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (sel == SEL_W'(i)) begin
        op_sel  = op_q[i];
        cnt_sel = cnt_q[i];
      end
    end
    sel_full = (cnt_sel == CNT_W'(DIGITS));
    op_shift = (op_sel << DIGIT_W) | OP_W'(digit);
    clear    = clr_s | (ops_valid & ops_ready);
    do_key   = evt & ~clear;
  end

  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) begin
      op_d[i]  = op_q[i];
      cnt_d[i] = cnt_q[i];
    end
    ovf_d      = ovf;
    last_sel_d = last_sel_q;

    if (clear) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        op_d[i]  = '0;
        cnt_d[i] = '0;
      end
      ovf_d = 1'b0;
    end else if (do_key) begin
      last_sel_d = sel;
      if (sel_full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_OPS; i++) begin
          if (sel == SEL_W'(i)) begin
            op_d[i]  = op_shift;
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    ind_d      = '0;
    all_filled = 1'b1;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (last_sel_d == SEL_W'(i)) ind_d = op_d[i];
      if (cnt_d[i] == '0)          all_filled = 1'b0;
    end
  end

  always_ff @(posedge clk_sw or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        op_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ovf        <= 1'b0;
      ind        <= '0;
      last_sel_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        op_q[i]  <= op_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ovf        <= ovf_d;
      ind        <= ind_d;
      last_sel_q <= last_sel_d;
    end
  end

  always_ff @(posedge clk_sw or negedge rst_n) begin
    if (!rst_n) state_q <= ENTRY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)                                 state_d = ENTRY;
    else if (state_q == ENTRY && all_filled)   state_d = READY;
  end

  // ops_valid is the READY flop itself, so it rises with the completing digit.
  always_comb begin
    ops_valid = (state_q == READY);
  end

  always_comb begin
    ops_bus = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      ops_bus[i*OP_W +: OP_W] = op_q[i];
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a per-cycle reference model of operand entry.
module tb_operand_entry;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 2;
  localparam int NUM_OPS = 2;
  localparam int OP_W    = DIGIT_W * DIGITS;
  localparam int KEY_W   = 2;

  logic                    clk_sw = 1'b0;
  logic                    rst_n  = 1'b0;
  logic [DIGIT_W-1:0]      in_num = 4'hF;
  logic [KEY_W-1:0]        key    = '0;
  logic                    clr    = 1'b0;
  logic                    ops_ready = 1'b0;
  logic [NUM_OPS*OP_W-1:0] ops_bus;
  logic                    ops_valid;
  logic                    ovf;
  logic [OP_W-1:0]         ind;

  int checks   = 0;
  int failures = 0;

  int m_op  [NUM_OPS];
  int m_cnt [NUM_OPS];
  int m_last;
  int m_kprev;
  bit m_ovf;

  always #5 clk_sw = ~clk_sw;

  operand_entry dut (
    .clk_sw             (clk_sw),
    .rst_n              (rst_n),
    .in_number_from_top (in_num),
    .key_from_top       (key),
    .clr_from_top       (clr),
    .ops_ready          (ops_ready),
    .ops_bus            (ops_bus),
    .ops_valid          (ops_valid),
    .ovf                (ovf),
    .ind                (ind)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_valid();
    for (int i = 0; i < NUM_OPS; i++) if (m_cnt[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: operands as integers, value = value*16 + digit while digits remain.
  always @(posedge clk_sw or negedge rst_n) begin
    int  d;
    int  k;
    bit  clear;
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        m_op[i]  = 0;
        m_cnt[i] = 0;
      end
      m_last  = 0;
      m_kprev = 0;
      m_ovf   = 1'b0;
    end else begin
      d     = int'(~in_num) & ((1 << DIGIT_W) - 1);
      k     = int'(key);
      clear = clr || (m_valid() && ops_ready);
      if (clear) begin
        for (int i = 0; i < NUM_OPS; i++) begin
          m_op[i]  = 0;
          m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
      end else if (k != m_kprev && k >= 1 && k <= NUM_OPS) begin
        if (m_cnt[k-1] < DIGITS) begin
          m_op[k-1]  = (m_op[k-1] * (1 << DIGIT_W) + d) % (1 << OP_W);
          m_cnt[k-1] = m_cnt[k-1] + 1;
        end else begin
          m_ovf = 1'b1;
        end
        m_last = k - 1;
      end
      m_kprev = k;
    end
  end

  always @(negedge clk_sw) begin
    logic [NUM_OPS*OP_W-1:0] exp_bus;
    if (rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) exp_bus[i*OP_W +: OP_W] = OP_W'(m_op[i]);
      chk("model_ops_bus", 32'(ops_bus), 32'(exp_bus));
      chk("model_ops_valid", 32'(ops_valid), 32'(m_valid()));
      chk("model_ovf", 32'(ovf), 32'(m_ovf));
      chk("model_ind", 32'(ind), 32'(OP_W'(m_op[m_last])));
    end
  end

  task automatic tick();
    @(negedge clk_sw);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_bus", 32'(ops_bus), 32'h0);
    chk("rst_valid", 32'(ops_valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_ind", 32'(ind), 32'h0);
    #10 rst_n = 1'b1;

    // key 1 held five cycles, digit 3
    tick();
    key = 2'd1; in_num = 4'b1100;
    chk("t1_ind_before_edge", 32'(ind), 32'h00);
    tick();
    chk("t1_ind_after_edge", 32'(ind), 32'h03);
    repeat (4) tick();
    chk("t1_single_shift", 32'(ops_bus), 32'h0003);

    // 1 -> 0 -> 1 with digit 5, then overflow attempt
    key = 2'd0; in_num = 4'b1010;
    tick();
    key = 2'd1;
    tick();
    chk("t2_op0", 32'(ops_bus), 32'h0035);
    chk("t2_no_ovf", 32'(ovf), 32'h0);
    key = 2'd0;
    tick();
    key = 2'd1;
    tick();
    chk("t2_op0_full", 32'(ops_bus), 32'h0035);
    chk("t2_ovf", 32'(ovf), 32'h1);
    chk("t2_not_valid", 32'(ops_valid), 32'h0);

    // complete operand 1 with digit 1
    key = 2'd2; in_num = 4'b1110;
    tick();
    chk("t3_bus", 32'(ops_bus), 32'h0135);
    chk("t3_valid", 32'(ops_valid), 32'h1);
    chk("t3_ind", 32'(ind), 32'h01);

    // handshake
    key = 2'd0; ops_ready = 1'b1;
    tick();
    ops_ready = 1'b0;
    chk("t4_valid_low", 32'(ops_valid), 32'h0);
    chk("t4_bus_zero", 32'(ops_bus), 32'h0);
    chk("t4_ovf_zero", 32'(ovf), 32'h0);

    // ops_ready in ENTRY is ignored
    ops_ready = 1'b1; key = 2'd1; in_num = 4'b1100;
    tick();
    chk("t4_entry_ready_ignored", 32'(ops_bus), 32'h0003);
    ops_ready = 1'b0; key = 2'd2; in_num = 4'b1101;
    tick();
    chk("t4_refill_bus", 32'(ops_bus), 32'h0203);
    chk("t4_refill_valid", 32'(ops_valid), 32'h1);

    // clear + handshake + key event in one cycle
    clr = 1'b1; ops_ready = 1'b1; key = 2'd1; in_num = 4'b1100;
    tick();
    clr = 1'b0; ops_ready = 1'b0;
    chk("t5_cleared", 32'(ops_bus), 32'h0);
    chk("t5_valid_low", 32'(ops_valid), 32'h0);
    tick();
    chk("t5_key_dropped", 32'(ops_bus), 32'h0);

    // async reset mid-entry with key held across release
    key = 2'd0;
    tick();
    key = 2'd1; in_num = 4'b1100;
    tick();
    chk("t6_pre_reset", 32'(ops_bus), 32'h0003);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_bus", 32'(ops_bus), 32'h0);
    chk("t6_async_ind", 32'(ind), 32'h0);
    chk("t6_async_valid", 32'(ops_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_event_after_reset", 32'(ops_bus), 32'h0003);
    tick();
    chk("t6_held_no_repeat", 32'(ops_bus), 32'h0003);

    // out-of-range code ignored but remembered
    key = 2'd3;
    tick();
    chk("t7_code3_ignored", 32'(ops_bus), 32'h0003);
    key = 2'd1;
    tick();
    chk("t7_return_fires", 32'(ops_bus), 32'h0033);
    chk("t7_ind", 32'(ind), 32'h33);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Parametrised successor to the calculator's switch-input stage.
- Accumulates multi-digit operands from the digit switches into NUM_OPS operand registers; the key selects which operand receives each digit.
- Each key press is counted once, on its edge.
- Presents the completed operand set to the ALU through a valid/ready handshake and drives the indicator with the operand being edited.

Parameters:
- DIGIT_W, 4: bits per entered digit (switch count).
- DIGITS, 2: maximum digits per operand; OP_W = DIGIT_W*DIGITS.
- NUM_OPS, 2: number of operand registers; key code k (1..NUM_OPS) selects operand k-1.
- INVERT_IN, 1: 1 = switches are active-low and are inverted before use; 0 = switches used as-is.

Ports:
- clk_sw  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_number_from_top  in  DIGIT_W  raw digit switches.
- key_from_top  in  KEY_W=$clog2(NUM_OPS+1)  0 = idle, k = enter digit into operand k-1.
- clr_from_top  in  1  synchronous clear of all operands.
- ops_ready  in  1  ALU accepts operand set.
- ops_bus  out  NUM_OPS*OP_W  operand k-1 at bits [k*OP_W-1 -: OP_W].
- ops_valid  out  1  all operands hold at least one digit.
- ovf  out  1  sticky: a digit was entered into a full operand.
- ind  out  OP_W  value of the last-selected operand.

Behaviour:
- Reset: rst_n low clears the following asynchronously:
  - ops_bus, ind, ovf, ops_valid, all digit counters, key_prev and last_sel;
  - the state machine goes to ENTRY.
- Digit value: d = INVERT_IN ? ~in_number_from_top : in_number_from_top.
- Key event: key_from_top != key_prev and key_from_top in 1..NUM_OPS.
  - key_prev is registered every cycle.
  - A key held for many cycles produces exactly one event.
  - A direct change from k1 to k2 is an event for k2.
  - Codes above NUM_OPS are ignored, but still update key_prev.
- ENTRY state, on an event for k:
  - If cnt[k-1] < DIGITS: op[k-1] <= {op[k-1][OP_W-DIGIT_W-1:0], d} and cnt[k-1]++.
  - Otherwise op[k-1] is unchanged and ovf <= 1.
  - In both cases last_sel <= k-1.
  - Register update is visible the cycle after the event edge (latency 1).
- ind = op[last_sel], registered; it updates in the same cycle as the operand.
- ENTRY -> READY: when every cnt is nonzero. ops_valid is registered and asserts in the same cycle as the completing digit.
- READY state:
  - Further key events still shift digits into operands, with the same rules as ENTRY.
  - ops_valid stays high and ops_bus remains valid.
  - ALU requirement: sample ops_bus only on the handshake cycle.
- Handshake: ops_valid & ops_ready at a clock edge does the following:
  - clears all cnt, op, ind and ovf;
  - deasserts ops_valid;
  - returns the state machine to ENTRY.
  - ops_ready while in ENTRY has no effect.
- clr_from_top: same clearing action as a handshake, in any state.
  - Priority: clr > handshake > key event.
  - A key event in the same cycle as clr or a handshake is dropped, but key_prev still updates.
- Reset asserted mid-entry or mid-handshake: everything is cleared immediately, with no pending pulse afterwards.

Optional Feature:
- Macro: OPERAND_ENTRY_SYNC_EN.
- Defined:
  - in_number_from_top, key_from_top and clr_from_top each pass through a 2-flop synchroniser, reset to 0 by rst_n.
  - All entry latencies grow by 2 cycles.
  - Digit and key are synchronised together, so the same-cycle relationship between them is preserved.
- Undefined: inputs are used directly, with latency as specified above.

Decomposition:
- Package calc_pkg:
  - default DIGIT_W;
  - state enum {ENTRY, READY};
  - a key-width function clog2(NUM_OPS+1);
  - KEY_IDLE = 0.
- Sub-module key_edge_det:
  - contains the key_prev register and the event/select decode;
  - parametrised by KEY_W and NUM_OPS;
  - outputs evt and sel.

Test Plan (defaults DIGIT_W=4, DIGITS=2, NUM_OPS=2, INVERT_IN=1):
- Reset, then key=1 held 5 cycles with in=4'b1100 -> op0=8'h03, cnt0=1; exactly one shift occurs; ind=8'h03 one cycle after the edge.
- key 1 -> 0 -> 1 with in=4'b1010 -> op0=8'h35; then key 0 -> 1 a third time -> op0 stays 8'h35 and ovf=1.
- Load op0=8'h35, then key=2 with in=4'b1110 -> op1=8'h01; ops_valid=1; ops_bus=16'h0135.
- In READY with ops_ready=1 for one cycle -> next cycle ops_valid=0, ops_bus=0, ovf=0, state ENTRY.
- clr_from_top, ops_ready and a key-1 event in the same cycle while READY -> all operands cleared; the digit is dropped.
- rst_n pulsed low asynchronously mid-entry (between clock edges) -> outputs are 0 immediately; key held at 1 across reset release -> one new event after reset, since key_prev was cleared to 0.
